// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BP_GSHARE_EN to index the counter table by pc_index ^ global history.
module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic                  upd_is_cond,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [ADDR_WIDTH-1:0] upd_pred_target,
  output logic                  mispredict
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic [ENTRIES-1:0]    valid_q;
  logic [ENTRIES-1:0]    uncond_q;
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx, upd_idx, fetch_cidx, upd_cidx;
  logic [TAG_BITS-1:0]   fetch_tag, upd_tag;
  logic                  fetch_hit, upd_hit;
  logic [1:0]            cur_ctr, next_ctr;

  assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag = fetch_pc[TAG_HI:TAG_LO];
  assign upd_idx   = upd_pc[INDEX_BITS+1:2];
  assign upd_tag   = upd_pc[TAG_HI:TAG_LO];

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  // History is non-speculative: only resolved conditional branches shift in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (upd_valid && upd_is_cond) begin
      ghr <= {ghr[INDEX_BITS-2:0], upd_taken};
    end
  end

  assign fetch_cidx = fetch_idx ^ ghr;
  assign upd_cidx   = upd_idx ^ ghr;
`else
  assign fetch_cidx = fetch_idx;
  assign upd_cidx   = upd_idx;
`endif

  assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken  = fetch_hit && (uncond_q[fetch_idx] || ctr_q[fetch_cidx][1]);
  assign pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + ADDR_WIDTH'(4);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    cur_ctr  = ctr_q[upd_cidx];
    next_ctr = cur_ctr;
    if (upd_taken) begin
      if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'b01;
    end
  end

  // No handshake: upd_valid is sampled every rising edge and at most one
  // update lands per cycle; lookups in the same cycle see pre-update state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_is_cond) ctr_q[upd_cidx] <= next_ctr;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_cidx]  <= upd_is_cond ? 2'b10 : 2'b11;
      end
    end
  end

  // Payload fields need no reset; an entry is meaningless while valid is 0.
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      if (upd_hit) begin
        if (!upd_is_cond || upd_taken) target_q[upd_idx] <= upd_target;
        if (!upd_is_cond) uncond_q[upd_idx] <= 1'b1;
      end else if (upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        uncond_q[upd_idx] <= !upd_is_cond;
      end
    end
  end

  assign mispredict = !rst && upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], fetch_pc[ADDR_WIDTH-1:TAG_HI+1],
                            upd_pc[1:0], upd_pc[ADDR_WIDTH-1:TAG_HI+1]};
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; driver pushes expectations, a negedge monitor checks them.
module tb_branch_predictor;
  localparam int AW = 32;
  localparam int EW = AW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] fetch_pc;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          upd_valid;
  logic          upd_is_cond;
  logic [AW-1:0] upd_pc;
  logic          upd_taken;
  logic [AW-1:0] upd_target;
  logic          upd_pred_taken;
  logic [AW-1:0] upd_pred_target;
  logic          mispredict;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            total = 0;
  int            bad = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic cond, input logic [AW-1:0] pc, input logic tk,
                           input logic [AW-1:0] tgt, input logic ptk,
                           input logic [AW-1:0] ptgt);
    upd_valid       = 1'b1;
    upd_is_cond     = cond;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  task automatic upd(input logic cond, input logic [AW-1:0] pc, input logic tk,
                     input logic [AW-1:0] tgt);
    drive_upd(cond, pc, tk, tgt, tk, tgt);
    step();
    upd_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [AW-1:0] pc, input logic tk,
                            input logic [AW-1:0] tgt, input logic mis);
    fetch_pc = pc;
    exp_q.push_back({tk, tgt, mis});
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if ({pred_taken, pred_target, mispredict} !== e) begin
        bad++;
        $display("FAIL %s: got taken=%0b target=%h mis=%0b, want taken=%0b target=%h mis=%0b",
                 nm, pred_taken, pred_target, mispredict, e[EW-1], e[AW:1], e[0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    fetch_pc = 32'h100;
    upd_valid = 1'b0; upd_is_cond = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    expect_out("in_reset", 32'h100, 1'b0, 32'h104, 1'b0);
    step();
    rst = 1'b0;
    expect_out("reset_release", 32'h100, 1'b0, 32'h104, 1'b0);

    // allocate 0x100: same-cycle lookup sees old state, update flags mispredict
    step();
    drive_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    expect_out("alloc_cycle", 32'h100, 1'b0, 32'h104, 1'b1);
    step();
    upd_valid = 1'b0;
    expect_out("alloc_hit", 32'h100, 1'b1, 32'h80, 1'b0);

    // two not-taken: 10 -> 01 -> 00
    step();
    upd(1'b1, 32'h100, 1'b0, 32'h0);
    upd(1'b1, 32'h100, 1'b0, 32'h0);
    expect_out("ctr_down_00", 32'h100, 1'b0, 32'h104, 1'b0);

    // taken: 00 -> 01 still not taken, then up to saturation and one step back
    step();
    upd(1'b1, 32'h100, 1'b1, 32'h80);
    expect_out("ctr_01", 32'h100, 1'b0, 32'h104, 1'b0);
    step();
    upd(1'b1, 32'h100, 1'b1, 32'h80);
    upd(1'b1, 32'h100, 1'b1, 32'h80);
    upd(1'b1, 32'h100, 1'b1, 32'h80);
    upd(1'b1, 32'h100, 1'b0, 32'h0);
    expect_out("sat_then_10", 32'h100, 1'b1, 32'h80, 1'b0);

    // not-taken miss at 0x300 (same index, other tag) must not allocate
    step();
    upd(1'b1, 32'h300, 1'b0, 32'h0);
    expect_out("nt_miss_noalloc", 32'h100, 1'b1, 32'h80, 1'b0);

    // same-cycle lookup during update returns pre-update counter (10 -> 01)
    step();
    drive_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    expect_out("no_bypass", 32'h100, 1'b1, 32'h80, 1'b1);
    step();
    upd_valid = 1'b0;
    expect_out("after_bypass", 32'h100, 1'b0, 32'h104, 1'b0);

    // mispredict on target mismatch, then correct prediction (ctr 01->10->11)
    step();
    drive_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h84);
    expect_out("mis_target", 32'h40, 1'b0, 32'h44, 1'b1);
    step();
    drive_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    expect_out("mis_none", 32'h40, 1'b0, 32'h44, 1'b0);
    step();
    upd_valid = 1'b0;
    expect_out("hit_after_mis", 32'h100, 1'b1, 32'h80, 1'b0);

    // aliasing: 0x200 shares index 0 and evicts 0x100
    step();
    upd(1'b1, 32'h200, 1'b1, 32'h500);
    expect_out("alias_evicted", 32'h100, 1'b0, 32'h104, 1'b0);
    expect_out("alias_new", 32'h200, 1'b1, 32'h500, 1'b0);

    // jal on the hit entry: uncond sticks through not-taken updates
    step();
    upd(1'b0, 32'h200, 1'b1, 32'h400);
    expect_out("jal_hit", 32'h200, 1'b1, 32'h400, 1'b0);
    step();
    upd(1'b1, 32'h200, 1'b0, 32'h0);
    upd(1'b1, 32'h200, 1'b0, 32'h0);
    expect_out("jal_sticky", 32'h200, 1'b1, 32'h400, 1'b0);
    step();
    upd(1'b0, 32'h204, 1'b1, 32'h600);
    expect_out("jal_alloc", 32'h204, 1'b1, 32'h600, 1'b0);

    expect_out("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);

    // reset during an update: mispredict masked, update discarded, table cleared
    step();
    drive_upd(1'b1, 32'h104, 1'b1, 32'h700, 1'b0, 32'h0);
    rst = 1'b1;
    expect_out("rst_mid", 32'h200, 1'b0, 32'h204, 1'b0);
    step();
    rst = 1'b0;
    upd_valid = 1'b0;
    expect_out("rst_no_write", 32'h104, 1'b0, 32'h108, 1'b0);
    expect_out("rst_cleared", 32'h200, 1'b0, 32'h204, 1'b0);
    expect_out("rst_cleared_jal", 32'h204, 1'b0, 32'h208, 1'b0);

    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got pending=%0d, want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
